lc3_mem_ctrl: RTL and testbench

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

---
 rtl/lc3_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: MAR/MDR front end for the control FSM, a variable-latency
// RAM port, and the memory-mapped keyboard, display and machine-control registers.
module lc3_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ldMAR,
  input  logic [15:0] addr_in,
  input  logic        memWE,
  input  logic [15:0] wdata,
  output logic        memRDY,
  output logic [15:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  input  logic        dsp_ready,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  output logic        run
);

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

  typedef enum logic [2:0] {
    IDLE, RAM_RD, RAM_WR, IO_RD, IO_WR, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] acc_addr_q, acc_addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rd_pend_q, rd_pend_d;
  logic        kbd_ready_q, kbd_ready_d;
  logic [7:0]  kbd_char_q, kbd_char_d;
  logic        dsp_rdy_q, dsp_rdy_d;
  logic        run_q, run_d;

  logic        busy;
  logic        fin;
  logic        pend;
  logic        kbdr_clr;
  logic        ddr_wr;
  logic [15:0] io_val;

  function automatic logic is_io(input logic [15:0] a);
    return (a == ADDR_KBSR) || (a == ADDR_KBDR) || (a == ADDR_DSR) ||
           (a == ADDR_DDR)  || (a == ADDR_MCR);
  endfunction

  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    acc_addr_d  = acc_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rd_pend_d   = rd_pend_q;
    kbd_ready_d = kbd_ready_q;
    kbd_char_d  = kbd_char_q;
    dsp_rdy_d   = dsp_rdy_q;
    run_d       = run_q;
    kbdr_clr    = 1'b0;
    fin         = 1'b0;
    pend        = rd_pend_q | ldMAR;
    busy        = (state_q != IDLE) && (state_q != DONE);
    ddr_wr      = (state_q == IO_WR) && (acc_addr_q == ADDR_DDR);

    case (acc_addr_q)
      ADDR_KBSR: io_val = {kbd_ready_q, 15'b0};
      ADDR_KBDR: io_val = {8'b0, kbd_char_q};
      ADDR_DSR:  io_val = {dsp_rdy_q, 15'b0};
      ADDR_MCR:  io_val = {run_q, 15'b0};
      default:   io_val = 16'h0000;
    endcase

    case (state_q)
      RAM_RD, RAM_WR: fin = mem_ack;
      IO_RD, IO_WR:   fin = 1'b1;
      default:        fin = 1'b0;
    endcase

    if (!busy) begin
      state_d = IDLE;
      // A write always targets the MAR as it stood before this edge.
      if (memWE) begin
        wdata_d    = wdata;
        acc_addr_d = mar_q;
        state_d    = is_io(mar_q) ? IO_WR : RAM_WR;
        if (ldMAR) begin
          mar_d     = addr_in;
          rd_pend_d = 1'b1;
        end
      end else if (ldMAR) begin
        mar_d      = addr_in;
        acc_addr_d = addr_in;
        state_d    = is_io(addr_in) ? IO_RD : RAM_RD;
      end
    end else begin
      if (ldMAR) mar_d = addr_in;
      if (fin) begin
        rd_pend_d = 1'b0;
        if (pend) begin
          // Superseded access: drop its data and chain straight into the new read.
          acc_addr_d = mar_d;
          state_d    = is_io(mar_d) ? IO_RD : RAM_RD;
        end else begin
          state_d = DONE;
          if (state_q == RAM_RD) rdata_d = mem_rdata;
          if (state_q == IO_RD) begin
            rdata_d  = io_val;
            kbdr_clr = (acc_addr_q == ADDR_KBDR);
          end
        end
        if ((state_q == IO_WR) && (acc_addr_q == ADDR_MCR)) run_d = wdata_q[15];
      end else begin
        rd_pend_d = pend;
      end
    end

    if (kbdr_clr) kbd_ready_d = 1'b0;
    if (kbd_valid) begin
      kbd_ready_d = 1'b1;
      kbd_char_d  = kbd_data;
    end

    if (ddr_wr) dsp_rdy_d = 1'b0;
    else if (dsp_ready) dsp_rdy_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mar_q       <= 16'h0000;
      acc_addr_q  <= 16'h0000;
      wdata_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      rd_pend_q   <= 1'b0;
      kbd_ready_q <= 1'b0;
      kbd_char_q  <= 8'h00;
      dsp_rdy_q   <= 1'b1;
      run_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      acc_addr_q  <= acc_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rd_pend_q   <= rd_pend_d;
      kbd_ready_q <= kbd_ready_d;
      kbd_char_q  <= kbd_char_d;
      dsp_rdy_q   <= dsp_rdy_d;
      run_q       <= run_d;
    end
  end

  assign memRDY    = (state_q == IDLE) || (state_q == DONE);
  assign rdata     = rdata_q;
  assign mem_req   = (state_q == RAM_RD) || (state_q == RAM_WR);
  assign mem_we    = (state_q == RAM_WR);
  assign mem_addr  = acc_addr_q;
  assign mem_wdata = wdata_q;
  assign dsp_valid = ddr_wr;
  assign dsp_data  = wdata_q[7:0];
  assign run       = run_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: RAM responder with programmable latency, a register model of
// the MMIO space, and expected queues for read data and RAM-port accesses.
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ldMAR, memWE;
  logic [15:0] addr_in, wdata;
  logic        memRDY;
  logic [15:0] rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        dsp_ready, dsp_valid;
  logic [7:0]  dsp_data;
  logic        run;

  logic        resp_ack, man_ack;
  logic [15:0] resp_rdata, man_rdata;
  assign mem_ack   = resp_ack | man_ack;
  assign mem_rdata = man_ack ? man_rdata : resp_rdata;

  lc3_mem_ctrl dut (
    .clk(clk), .rst(rst), .ldMAR(ldMAR), .addr_in(addr_in), .memWE(memWE), .wdata(wdata),
    .memRDY(memRDY), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .dsp_ready(dsp_ready),
    .dsp_valid(dsp_valid), .dsp_data(dsp_data), .run(run)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
  } acc_t;

  acc_t        acc_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] ram[logic [15:0]];
  logic [15:0] ref_mem[logic [15:0]];
  int          lat_fixed;
  bit          resp_en;

  bit          m_ready, m_dsp_rdy, m_run;
  logic [7:0]  m_char;
  logic [15:0] m_mar;

  int          dsp_cnt = 0;
  logic [7:0]  dsp_last = 8'h00;

  function automatic logic [15:0] ram_init(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  function automatic bit is_io_tb(input logic [15:0] a);
    return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) ||
           (a == 16'hFE06) || (a == 16'hFFFE);
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    logic [15:0] r;
    case (a)
      16'hFE00: r = {m_ready, 15'b0};
      16'hFE02: begin r = {8'h00, m_char}; m_ready = 1'b0; end
      16'hFE04: r = {m_dsp_rdy, 15'b0};
      16'hFE06: r = 16'h0000;
      16'hFFFE: r = {m_run, 15'b0};
      default:  r = ref_mem.exists(a) ? ref_mem[a] : ram_init(a);
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_ready = 1'b0; m_char = 8'h00; m_dsp_rdy = 1'b1; m_run = 1'b1; m_mar = 16'h0000;
  endtask

  // RAM responder: checks every request cycle against the expected access queue.
  initial begin
    int   cnt;
    bit   active;
    bit   known;
    acc_t cur;
    resp_ack = 1'b0; resp_rdata = 16'h0000; active = 0; cnt = 0; known = 0;
    cur = '{addr: 16'h0, we: 1'b0, data: 16'h0};
    forever begin
      @(negedge clk);
      if (resp_en) begin
        resp_ack = 1'b0;
        if (rst) active = 0;
        else if (mem_req) begin
          if (!active) begin
            active = 1; cnt = 0;
            known = (acc_q.size() != 0);
            if (known) cur = acc_q.pop_front();
            else check_val("unexpected_req", {15'b0, mem_req}, 16'h0000);
          end
          if (known) begin
            check_val("req_addr", mem_addr, cur.addr);
            check_val("req_we", {15'b0, mem_we}, {15'b0, cur.we});
            if (cur.we) check_val("req_wdata", mem_wdata, cur.data);
          end
          if (cnt == lat_fixed) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            resp_rdata = ram.exists(mem_addr) ? ram[mem_addr] : ram_init(mem_addr);
            resp_ack = 1'b1;
            active = 0;
          end else cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (dsp_valid) begin
      dsp_cnt  <= dsp_cnt + 1;
      dsp_last <= dsp_data;
    end
  end

  // Caller is in the first busy cycle with its strobes already released.
  task automatic wait_done(input bit is_read, input int exp_n, input string tag);
    int n;
    logic [15:0] e;
    n = 0;
    check_val({tag, "_busy"}, {15'b0, memRDY}, 16'h0000);
    while (!memRDY && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!memRDY) check_val({tag, "_timeout"}, {15'b0, memRDY}, 16'h0001);
    else begin
      check_val({tag, "_lat"}, n[15:0], exp_n[15:0]);
      if (is_read) begin
        if (exp_q.size() == 0) check_val({tag, "_noexp"}, rdata, 16'hxxxx);
        else begin
          e = exp_q.pop_front();
          check_val({tag, "_rdata"}, rdata, e);
        end
      end
    end
  endtask

  task automatic do_read(input logic [15:0] a, input string tag);
    @(negedge clk);
    ldMAR = 1'b1; addr_in = a; m_mar = a;
    exp_q.push_back(model_read(a));
    if (!is_io_tb(a)) acc_q.push_back('{addr: a, we: 1'b0, data: 16'h0});
    @(negedge clk);
    ldMAR = 1'b0;
    wait_done(1, is_io_tb(m_mar) ? 1 : lat_fixed + 1, tag);
  endtask

  task automatic do_write(input logic [15:0] d, input string tag);
    @(negedge clk);
    check_val({tag, "_rdy"}, {15'b0, memRDY}, 16'h0001);
    memWE = 1'b1; wdata = d;
    if (is_io_tb(m_mar)) begin
      if (m_mar == 16'hFE06) m_dsp_rdy = 1'b0;
      if (m_mar == 16'hFFFE) m_run = d[15];
    end else begin
      ref_mem[m_mar] = d;
      acc_q.push_back('{addr: m_mar, we: 1'b1, data: d});
    end
    @(negedge clk);
    memWE = 1'b0;
    wait_done(0, is_io_tb(m_mar) ? 1 : lat_fixed + 1, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [15:0] a;
    rst = 1'b1; ldMAR = 0; memWE = 0; addr_in = 0; wdata = 0;
    kbd_valid = 0; kbd_data = 0; dsp_ready = 0;
    man_ack = 0; man_rdata = 0;
    lat_fixed = 2; resp_en = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_memrdy", {15'b0, memRDY}, 16'h0001);
    check_val("rst_rdata", rdata, 16'h0000);
    check_val("rst_req", {14'b0, mem_req, mem_we}, 16'h0000);
    check_val("rst_dsp_valid", {15'b0, dsp_valid}, 16'h0000);
    check_val("rst_run", {15'b0, run}, 16'h0001);
    rst = 1'b0;

    do_read(16'hFE00, "kbsr_rst");
    do_read(16'hFE04, "dsr_rst");

    // RAM read, ack three cycles after request
    ram[16'h3000] = 16'h1234; ref_mem[16'h3000] = 16'h1234;
    lat_fixed = 3;
    do_read(16'h3000, "ram_rd");

    // write to x4000 then ldMAR x3001 the next cycle
    lat_fixed = 2;
    do_read(16'h4000, "mar4000");
    @(negedge clk);
    memWE = 1'b1; wdata = 16'hBEEF;
    acc_q.push_back('{addr: 16'h4000, we: 1'b1, data: 16'hBEEF});
    ref_mem[16'h4000] = 16'hBEEF;
    @(negedge clk);
    memWE = 1'b0; ldMAR = 1'b1; addr_in = 16'h3001; m_mar = 16'h3001;
    acc_q.push_back('{addr: 16'h3001, we: 1'b0, data: 16'h0});
    exp_q.push_back(model_read(16'h3001));
    @(negedge clk);
    ldMAR = 1'b0;
    wait_done(1, 2 * lat_fixed + 1, "wr_then_ld");
    do_read(16'h4000, "rdback4000");

    // memWE and ldMAR in the same cycle
    do_read(16'h3100, "mar3100");
    @(negedge clk);
    memWE = 1'b1; wdata = 16'hCAFE; ldMAR = 1'b1; addr_in = 16'h3101;
    acc_q.push_back('{addr: 16'h3100, we: 1'b1, data: 16'hCAFE});
    ref_mem[16'h3100] = 16'hCAFE; m_mar = 16'h3101;
    acc_q.push_back('{addr: 16'h3101, we: 1'b0, data: 16'h0});
    exp_q.push_back(model_read(16'h3101));
    @(negedge clk);
    memWE = 1'b0; ldMAR = 1'b0;
    wait_done(1, 2 * lat_fixed + 2, "wr_ld_same");
    do_read(16'h3100, "rdback3100");

    // ldMAR while a RAM read is in flight: first read's data is discarded
    @(negedge clk);
    ldMAR = 1'b1; addr_in = 16'h3200;
    acc_q.push_back('{addr: 16'h3200, we: 1'b0, data: 16'h0});
    @(negedge clk);
    addr_in = 16'h3201; m_mar = 16'h3201;
    acc_q.push_back('{addr: 16'h3201, we: 1'b0, data: 16'h0});
    exp_q.push_back(model_read(16'h3201));
    @(negedge clk);
    ldMAR = 1'b0;
    wait_done(1, 2 * lat_fixed + 1, "ld_midrd");

    // keyboard
    @(negedge clk);
    kbd_valid = 1'b1; kbd_data = 8'h41; m_ready = 1'b1; m_char = 8'h41;
    @(negedge clk);
    kbd_valid = 1'b0;
    do_read(16'hFE00, "kbsr_set");
    do_read(16'hFE02, "kbdr");
    do_read(16'hFE00, "kbsr_clr");

    // writes to KBSR are ignored but complete
    do_write(16'hFFFF, "kbsr_wr");
    do_read(16'hFE00, "kbsr_after_wr");

    // display
    do_read(16'hFE06, "ddr_rd");
    start = dsp_cnt;
    do_write(16'h0058, "ddr_wr");
    repeat (4) @(negedge clk);
    check_val("dsp_pulses", 16'(dsp_cnt - start), 16'h0001);
    check_val("dsp_data", {8'h00, dsp_last}, 16'h0058);
    do_read(16'hFE04, "dsr_busy");
    @(negedge clk);
    dsp_ready = 1'b1; m_dsp_rdy = 1'b1;
    @(negedge clk);
    dsp_ready = 1'b0;
    do_read(16'hFE04, "dsr_rdy");

    // machine control register and reset
    do_read(16'hFFFE, "mcr_rd");
    do_write(16'h0000, "mcr_wr");
    check_val("run_cleared", {15'b0, run}, 16'h0000);
    do_read(16'hFFFE, "mcr_rd0");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst2_run", {15'b0, run}, 16'h0001);
    check_val("rst2_memrdy", {15'b0, memRDY}, 16'h0001);
    check_val("rst2_rdata", rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0; model_reset();

    // random RAM traffic
    for (int i = 0; i < 10; i++) begin
      a = 16'h3300 + 16'($urandom_range(0, 7));
      lat_fixed = $urandom_range(0, 3);
      do_read(a, "rnd_rd");
      if ($urandom_range(0, 1) == 1) do_write(16'($urandom), "rnd_wr");
    end

    // reset during a RAM read that is never acknowledged
    resp_en = 0;
    @(negedge clk);
    ldMAR = 1'b1; addr_in = 16'h5000;
    @(negedge clk);
    ldMAR = 1'b0;
    repeat (3) @(negedge clk);
    check_val("hang_req", {15'b0, mem_req}, 16'h0001);
    check_val("hang_addr", mem_addr, 16'h5000);
    rst = 1'b1;
    #1;
    check_val("abort_req", {15'b0, mem_req}, 16'h0000);
    check_val("abort_memrdy", {15'b0, memRDY}, 16'h0001);
    @(negedge clk);
    rst = 1'b0; model_reset();
    @(negedge clk);
    man_ack = 1'b1; man_rdata = 16'hDEAD;
    @(negedge clk);
    man_ack = 1'b0;
    check_val("late_ack_rdy", {15'b0, memRDY}, 16'h0001);
    check_val("late_ack_rdata", rdata, 16'h0000);
    check_val("late_ack_req", {14'b0, mem_req, mem_we}, 16'h0000);
    resp_en = 1; lat_fixed = 1;
    do_read(16'h3000, "post_abort_rd");

    repeat (2) @(negedge clk);
    check_val("acc_q_empty", 16'(acc_q.size()), 16'h0000);
    check_val("exp_q_empty", 16'(exp_q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
